// File: rtl/axi_slv_pkg.sv
// Shared types and encodings for the AXI SRAM responder.
package axi_slv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_R_REQ,
    ST_R_DATA,
    ST_W_DATA,
    ST_B_RESP
  } state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  // wstrb is active-low on this port, so all-zero means every byte lane
  localparam logic [3:0] STRB_FULL = 4'b0000;

  // Only FIXED holds the address; WRAP and reserved encodings step like INCR.
  function automatic logic burst_steps(input logic [1:0] burst);
    return burst != BURST_FIXED;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Burst word-address and beat tracker shared by the read and write paths.
module axi_burst_addr_gen
  import axi_slv_pkg::*;
#(
  parameter int MEM_AW = 14,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              load,
  input  logic [MEM_AW-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  input  logic [1:0]        load_burst,
  input  logic              step,
  output logic [MEM_AW-1:0] addr,
  output logic              last
);

  logic [MEM_AW-1:0] addr_q;
  logic [LEN_W-1:0]  beat_q;
  logic [LEN_W-1:0]  len_q;
  logic              incr_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      addr_q <= '0;
      beat_q <= '0;
      len_q  <= '0;
      incr_q <= 1'b0;
    end else if (load) begin
      addr_q <= load_addr;
      beat_q <= '0;
      len_q  <= load_len;
      incr_q <= burst_steps(load_burst);
    end else if (step) begin
      beat_q <= beat_q + LEN_W'(1);
      // word address wraps naturally at the top of the macro
      if (incr_q) addr_q <= addr_q + MEM_AW'(1);
    end
  end

  assign addr = addr_q;
  assign last = (beat_q == len_q);

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 single-transaction responder in front of a single-port synchronous SRAM.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | accepting AR or AW, arbitrated when both are offered
// ST_R_REQ  | SRAM read access for the current beat
// ST_R_DATA | presenting read beat on R until rready
// ST_W_DATA | accepting W beats, each written to SRAM in its handshake cycle
// ST_B_RESP | presenting write response until bready
module axi_sram_slave
  import axi_slv_pkg::*;
#(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 8,
  parameter int MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [ID_W-1:0]   arid,
  input  logic [ADDR_W-1:0] araddr,
  input  logic [LEN_W-1:0]  arlen,
  input  logic [2:0]        arsize,
  input  logic [1:0]        arburst,
  input  logic              arvalid,
  output logic              arready,
  output logic [ID_W-1:0]   rid,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rlast,
  output logic              rvalid,
  input  logic              rready,
  input  logic [ID_W-1:0]   awid,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic [LEN_W-1:0]  awlen,
  input  logic [2:0]        awsize,
  input  logic [1:0]        awburst,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wlast,
  input  logic              wvalid,
  output logic              wready,
  output logic [ID_W-1:0]   bid,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic              mem_ce,
  output logic [3:0]        mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            state;
  logic              out_en;
  logic              last_wr;
  logic              rd_first;
  logic [ID_W-1:0]   id_q;
  logic [31:0]       rdata_q;
  logic [MEM_AW-1:0] cur_addr;
  logic              beat_last;
  logic              idle, both, ar_hns, aw_hns, w_hns, r_hns;
  logic              gen_load, gen_step;
  logic              unused_ok;

  // out_en keeps both address readys low until the first edge after reset
  assign idle    = out_en && (state == ST_IDLE);
  assign both    = arvalid && awvalid;
  assign arready = idle && !(both && !last_wr);
  assign awready = idle && !(both && last_wr);
  assign ar_hns  = arvalid && arready;
  assign aw_hns  = awvalid && awready;

  assign rvalid = (state == ST_R_DATA);
  assign r_hns  = rvalid && rready;
  assign rlast  = rvalid && beat_last;
  assign rdata  = rd_first ? mem_rdata : rdata_q;
  assign rid    = id_q;
  assign rresp  = RESP_OKAY;

  assign wready = (state == ST_W_DATA);
  assign w_hns  = wvalid && wready;

  assign bvalid = (state == ST_B_RESP);
  assign bid    = id_q;
  assign bresp  = RESP_OKAY;

  assign mem_ce    = (state == ST_R_REQ) || w_hns;
  assign mem_we    = w_hns ? ~wstrb : 4'b0000;
  assign mem_addr  = cur_addr;
  assign mem_wdata = w_hns ? wdata : 32'h0;

  assign gen_load = ar_hns || aw_hns;
  assign gen_step = (r_hns && !beat_last) || w_hns;

  axi_burst_addr_gen #(
    .MEM_AW (MEM_AW),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk        (clk),
    .rstn       (rstn),
    .load       (gen_load),
    .load_addr  (ar_hns ? araddr[MEM_AW+1:2] : awaddr[MEM_AW+1:2]),
    .load_len   (ar_hns ? arlen : awlen),
    .load_burst (ar_hns ? arburst : awburst),
    .step       (gen_step),
    .addr       (cur_addr),
    .last       (beat_last)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      out_en   <= 1'b0;
      last_wr  <= 1'b1;
      rd_first <= 1'b0;
      id_q     <= '0;
      rdata_q  <= '0;
    end else begin
      out_en   <= 1'b1;
      rd_first <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ar_hns) begin
            state   <= ST_R_REQ;
            id_q    <= arid;
            last_wr <= 1'b0;
          end else if (aw_hns) begin
            state   <= ST_W_DATA;
            id_q    <= awid;
            last_wr <= 1'b1;
          end
        end
        ST_R_REQ: begin
          state    <= ST_R_DATA;
          rd_first <= 1'b1;
        end
        ST_R_DATA: begin
          // SRAM output is only guaranteed for one cycle; hold it for stalls
          if (rd_first) rdata_q <= mem_rdata;
          if (rready) state <= beat_last ? ST_IDLE : ST_R_REQ;
        end
        ST_W_DATA: begin
          if (wvalid && beat_last) state <= ST_B_RESP;
        end
        ST_B_RESP: begin
          if (bready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign unused_ok = ^{arsize, awsize, wlast,
                       araddr[ADDR_W-1:MEM_AW+2], araddr[1:0],
                       awaddr[ADDR_W-1:MEM_AW+2], awaddr[1:0]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave with an SRAM model and a transaction-level reference.
module tb_axi_sram_slave;

  logic        clk, rstn;
  logic [7:0]  arid, awid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata, mem_wdata, mem_rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic [1:0]  arburst, awburst, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic [3:0]  wstrb, mem_we;
  logic        wlast, wvalid, wready, bvalid, bready, mem_ce;
  logic [13:0] mem_addr;

  typedef struct { logic [7:0] id; logic [31:0] data; logic last; } rexp_t;
  typedef struct { logic [13:0] addr; logic [31:0] data; logic [3:0] we; } wexp_t;

  rexp_t      rq[$];
  wexp_t      wq[$];
  logic [7:0] bq[$];

  logic [31:0] sram    [0:16383];
  logic [31:0] ref_mem [0:16383];
  logic        pre_en;
  logic [13:0] pre_addr;
  logic [31:0] pre_data;
  logic [31:0] last_rdata;
  logic [7:0]  last_rid;
  logic        last_rlast;

  int n_vec = 0;
  int n_err = 0;

  axi_sram_slave dut (
    .clk(clk), .rstn(rstn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // synchronous SRAM macro: read data appears the cycle after the access
  always @(posedge clk) begin
    if (pre_en) sram[pre_addr] <= pre_data;
    else if (mem_ce) begin
      if (mem_we == 4'b0000) mem_rdata <= sram[mem_addr];
      else for (int b = 0; b < 4; b++)
        if (mem_we[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison of DUT outputs against the reference queues
  always @(negedge clk) begin
    if (rstn) begin
      if (rvalid) begin
        if (rq.size() == 0) check("r_unexpected", 64'(rvalid), 64'd0);
        else begin
          check("rdata", 64'(rdata), 64'(rq[0].data));
          check("rid", 64'(rid), 64'(rq[0].id));
          check("rlast", 64'(rlast), 64'(rq[0].last));
          check("rresp", 64'(rresp), 64'd0);
          if (rready) void'(rq.pop_front());
        end
      end
      if (wvalid && wready) begin
        if (wq.size() == 0) check("w_unexpected", 64'(wready), 64'd0);
        else begin
          check("mem_ce_w", 64'(mem_ce), 64'd1);
          check("mem_addr_w", 64'(mem_addr), 64'(wq[0].addr));
          check("mem_wdata", 64'(mem_wdata), 64'(wq[0].data));
          check("mem_we", 64'(mem_we), 64'(wq[0].we));
          void'(wq.pop_front());
        end
      end else if (mem_ce) check("stray_write", 64'(mem_we), 64'd0);
      if (bvalid) begin
        if (bq.size() == 0) check("b_unexpected", 64'(bvalid), 64'd0);
        else begin
          check("bid", 64'(bid), 64'(bq[0]));
          check("bresp", 64'(bresp), 64'd0);
          if (bready) void'(bq.pop_front());
        end
      end
      if (rvalid || wready || bvalid) check("ready_busy", 64'({arready, awready}), 64'd0);
      if (arvalid && awvalid) check("arb_mask", 64'(arready && awready), 64'd0);
    end
  end

  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    pre_addr = a; pre_data = d; pre_en = 1'b1;
    @(posedge clk); #1;
    pre_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic do_read(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst, input bit toggle);
    logic [13:0] w;
    rexp_t e;
    int t, c, beats;
    bit got;
    w = addr[15:2];
    for (int k = 0; k <= int'(len); k++) begin
      e.id = id; e.data = ref_mem[w]; e.last = (k == int'(len));
      rq.push_back(e);
      if (burst != 2'b00) w = w + 14'd1;
    end
    arid = id; araddr = addr; arlen = len; arburst = burst; arsize = 3'd2; arvalid = 1'b1;
    t = 0; got = 0;
    while (!got && t < 100) begin
      @(negedge clk); got = arready; t++;
    end
    if (!got) begin
      check("ar_timeout", 64'(arready), 64'd1);
      arvalid = 1'b0; rq.delete();
      return;
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(negedge clk);
    check("r_req_ce", 64'(mem_ce), 64'd1);
    check("r_req_addr", 64'(mem_addr), 64'(addr[15:2]));
    check("r_req_rvalid", 64'(rvalid), 64'd0);
    @(posedge clk); #1;
    c = 0; beats = 0; rready = 1'b1;
    while (beats <= int'(len) && c < 2000) begin
      @(negedge clk);
      if (c == 0) check("r_lat", 64'(rvalid), 64'd1);
      if (rvalid && rready) begin
        beats++; last_rdata = rdata; last_rid = rid; last_rlast = rlast;
      end
      @(posedge clk); #1;
      c++;
      rready = toggle ? ((c & 2) == 0) : 1'b1;
    end
    rready = 1'b0;
    if (beats <= int'(len)) check("r_timeout", 64'(beats), 64'(int'(len) + 1));
  endtask

  task automatic do_write(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input logic [31:0] dbase, input bit data_idx,
                          input logic [3:0] strb);
    logic [13:0] w;
    logic [31:0] d;
    wexp_t e;
    int t, i;
    bit got, hns;
    w = addr[15:2];
    for (int k = 0; k <= int'(len); k++) begin
      d = data_idx ? 32'(k) : dbase + 32'(k);
      e.addr = w; e.data = d; e.we = ~strb;
      wq.push_back(e);
      for (int b = 0; b < 4; b++) if (!strb[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
      if (burst != 2'b00) w = w + 14'd1;
    end
    bq.push_back(id);
    awid = id; awaddr = addr; awlen = len; awburst = burst; awsize = 3'd2; awvalid = 1'b1;
    t = 0; got = 0;
    while (!got && t < 100) begin
      @(negedge clk); got = awready; t++;
    end
    if (!got) begin
      check("aw_timeout", 64'(awready), 64'd1);
      awvalid = 1'b0; wq.delete(); bq.delete();
      return;
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    i = 0; t = 0;
    wdata = data_idx ? 32'd0 : dbase; wstrb = strb; wlast = (len == 8'd0); wvalid = 1'b1;
    while (i <= int'(len) && t < 1000) begin
      @(negedge clk);
      if (t == 0) check("w_lat", 64'(wready), 64'd1);
      hns = wready && wvalid;
      @(posedge clk); #1;
      t++;
      if (hns) begin
        i++;
        wdata = data_idx ? 32'(i) : dbase + 32'(i);
        wlast = (i == int'(len));
      end
    end
    wvalid = 1'b0; wlast = 1'b0;
    if (i <= int'(len)) check("w_timeout", 64'(i), 64'(int'(len) + 1));
    @(negedge clk);
    check("b_lat", 64'(bvalid), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    n_err++;
    $display("FAIL watchdog: simulation did not finish");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    int nr, nw, nd, t;
    bit ga, gw, gd, seen;
    int gr[$];
    rexp_t re;
    wexp_t we;

    rstn = 1'b0; pre_en = 1'b0; pre_addr = '0; pre_data = '0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; rready = 1'b0; bready = 1'b1;
    #23;
    check("rst_ready", 64'({arready, awready, wready}), 64'd0);
    check("rst_valid", 64'({rvalid, rlast, bvalid}), 64'd0);
    check("rst_rdata", 64'({rdata, rid, rresp}), 64'd0);
    check("rst_b", 64'({bid, bresp}), 64'd0);
    check("rst_mem", 64'({mem_ce, mem_we, mem_addr}), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);

    preload(14'h0010, 32'hDEADBEEF);
    for (int k = 0; k < 4; k++) preload(14'h0040 + 14'(k), 32'hA000_0000 + 32'(k));
    preload(14'h0080, 32'h1234_5678);
    preload(14'h0081, 32'hA5A5_A5A5);
    preload(14'h0090, 32'h0);
    preload(14'h0300, 32'h5EED_0300);
    preload(14'h0301, 32'h0);
    preload(14'h3FFF, 32'h0);
    preload(14'h0000, 32'h0);
    for (int k = 0; k < 4; k++) preload(14'h00A0 + 14'(k), 32'hC0DE_00A0 + 32'(k));
    rstn = 1'b1;

    // both address channels held for two transactions each: expect R,W,R,W
    for (int k = 0; k < 2; k++) begin
      re.id = 8'h11; re.data = 32'h5EED_0300; re.last = 1'b1; rq.push_back(re);
      we.addr = 14'h0301; we.data = 32'hCAFE_0001; we.we = 4'hF; wq.push_back(we);
      bq.push_back(8'h22);
    end
    ref_mem[14'h0301] = 32'hCAFE_0001;
    arid = 8'h11; araddr = 32'h0C00; arlen = 8'd0; arburst = 2'b01; arsize = 3'd2; arvalid = 1'b1;
    awid = 8'h22; awaddr = 32'h0C04; awlen = 8'd0; awburst = 2'b01; awsize = 3'd2; awvalid = 1'b1;
    wdata = 32'hCAFE_0001; wstrb = 4'b0000; wlast = 1'b1; wvalid = 1'b1; rready = 1'b1;
    nr = 0; nw = 0; nd = 0; t = 0;
    while ((nr < 2 || nw < 2 || nd < 2) && t < 200) begin
      @(negedge clk);
      ga = arvalid && arready; gw = awvalid && awready; gd = wvalid && wready;
      @(posedge clk); #1;
      t++;
      if (ga) begin gr.push_back(0); nr++; if (nr == 2) arvalid = 1'b0; end
      if (gw) begin gr.push_back(1); nw++; if (nw == 2) awvalid = 1'b0; end
      if (gd) begin nd++; if (nd == 2) begin wvalid = 1'b0; wlast = 1'b0; end end
    end
    repeat (4) @(posedge clk);
    #1 rready = 1'b0;
    check("arb_count", 64'(gr.size()), 64'd4);
    for (int k = 0; k < gr.size() && k < 4; k++) check($sformatf("arb_%0d", k), 64'(gr[k]), 64'(k % 2));
    check("arb_drain", 64'(rq.size() + wq.size() + bq.size()), 64'd0);

    do_read(8'h21, 32'h0000_0040, 8'd0, 2'b01, 1'b0);
    check("t1_rdata", 64'(last_rdata), 64'h0000_0000_DEAD_BEEF);
    check("t1_rid_rlast", 64'({last_rid, last_rlast}), 64'h043);

    do_read(8'h05, 32'h0000_0100, 8'd3, 2'b01, 1'b1);
    check("t2_last", 64'(last_rdata), 64'h0000_0000_A000_0003);

    do_write(8'h3C, 32'h0000_0200, 8'hFF, 2'b00, 32'h0, 1'b1, 4'b0000);
    check("t3_w80", 64'(sram[14'h0080]), 64'h0000_0000_0000_00FF);
    check("t3_w81", 64'(sram[14'h0081]), 64'h0000_0000_A5A5_A5A5);
    do_read(8'h3D, 32'h0000_0200, 8'd1, 2'b01, 1'b0);

    do_write(8'h07, 32'h0000_0240, 8'd0, 2'b01, 32'h1122_3344, 1'b0, 4'b1010);
    check("t4_partial", 64'(sram[14'h0090]), 64'h0000_0000_0022_0044);
    do_read(8'h08, 32'h0000_0240, 8'd0, 2'b01, 1'b0);

    do_write(8'h09, 32'h0001_FFFC, 8'd1, 2'b01, 32'h7000_0000, 1'b0, 4'b0000);
    check("t5_top", 64'(sram[14'h3FFF]), 64'h0000_0000_7000_0000);
    check("t5_wrap", 64'(sram[14'h0000]), 64'h0000_0000_7000_0001);
    do_read(8'h0A, 32'h0000_FFFC, 8'd1, 2'b01, 1'b0);

    // reset in the middle of a 4-beat write, after beats 0 and 1
    for (int k = 0; k < 2; k++) begin
      we.addr = 14'h00A0 + 14'(k); we.data = 32'hBEEF_0000 + 32'(k); we.we = 4'hF;
      wq.push_back(we);
      ref_mem[we.addr] = we.data;
    end
    awid = 8'h44; awaddr = 32'h0000_0280; awlen = 8'd3; awburst = 2'b01; awsize = 3'd2; awvalid = 1'b1;
    t = 0; seen = 0;
    while (!seen && t < 100) begin @(negedge clk); seen = awready; t++; end
    check("t6_aw", 64'(seen), 64'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wdata = 32'hBEEF_0000; wstrb = 4'b0000; wvalid = 1'b1;
    nd = 0; t = 0;
    while (nd < 2 && t < 100) begin
      @(negedge clk); gd = wvalid && wready;
      @(posedge clk); #1;
      t++;
      if (gd) begin nd++; wdata = 32'hBEEF_0000 + 32'(nd); end
    end
    check("t6_beats", 64'(nd), 64'd2);
    #2 rstn = 1'b0;
    #1;
    check("t6_rst_ready", 64'({arready, awready, wready}), 64'd0);
    check("t6_rst_valid", 64'({rvalid, bvalid, mem_ce}), 64'd0);
    check("t6_rst_bid_we", 64'({bid, mem_we}), 64'd0);
    @(posedge clk); #1;
    wvalid = 1'b0;
    @(posedge clk); #3;
    rstn = 1'b1;
    seen = 0;
    repeat (10) begin @(negedge clk); if (bvalid) seen = 1; end
    check("t6_no_b", 64'(seen), 64'd0);
    check("t6_w0", 64'(sram[14'h00A0]), 64'h0000_0000_BEEF_0000);
    check("t6_w1", 64'(sram[14'h00A1]), 64'h0000_0000_BEEF_0001);
    check("t6_w2", 64'(sram[14'h00A2]), 64'h0000_0000_C0DE_00A2);
    check("t6_w3", 64'(sram[14'h00A3]), 64'h0000_0000_C0DE_00A3);
    @(posedge clk); #1;
    do_read(8'h45, 32'h0000_0280, 8'd3, 2'b01, 1'b0);

    repeat (3) @(posedge clk);
    check("final_drain", 64'(rq.size() + wq.size() + bq.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI4 responder that serves burst read/write transactions from an AXI master (CPU, DMA) onto one single-port synchronous SRAM macro. It sits behind an interconnect slave port, handles one transaction at a time, and supports FIXED and INCR bursts of up to 256 beats. These are the bursts the DMA issues: arlen/awlen up to 8'hff, FIXED burst, full-word strobes.

## Interface
- ID_W, 8: arid/awid/rid/bid width (interconnect-extended ID)
- ADDR_W, 32: AXI address width
- LEN_W, 8: arlen/awlen width
- MEM_AW, 14: SRAM word-address width; byte address bits [MEM_AW+1:2] select the word
- clk  in  1  clock
- rstn  in  1  reset; one clock; reset is asynchronous and active-low
- arid/araddr/arlen/arsize/arburst/arvalid  in  ID_W/ADDR_W/LEN_W/3/2/1  read address channel
- arready  out  1
- rid/rdata/rresp/rlast/rvalid  out  ID_W/32/2/1/1  read data channel
- rready  in  1
- awid/awaddr/awlen/awsize/awburst/awvalid  in  ID_W/ADDR_W/LEN_W/3/2/1  write address channel
- awready  out  1
- wdata/wstrb/wlast/wvalid  in  32/4/1/1  write data; wstrb active-low (4'b0000 = full word)
- wready  out  1
- bid/bresp/bvalid  out  ID_W/2/1; bready  in  1
- mem_ce  out  1  SRAM access enable
- mem_we  out  4  active-high byte write enables (= ~wstrb during a write); 0 = read
- mem_addr  out  MEM_AW  word address
- mem_wdata  out  32; mem_rdata  in  32  valid the cycle after a read access

## Operation
- FSM states: IDLE, R_REQ, R_DATA, W_DATA, B_RESP.
- IDLE: arready=1 and awready=1 unless arbitration masks one side. On arhns, latch id/addr/len/burst and go to R_REQ. On awhns, latch them and go to W_DATA.
- Arbitration: when arvalid and awvalid are both high in IDLE, grant the side not granted last; the flag resets to "write last", so read wins first. Only the granted side sees ready=1.
- R_REQ: mem_ce=1, mem_we=0, mem_addr=cur addr. Next state R_DATA; rdata register captures mem_rdata on entry.
- R_DATA: rvalid=1, rlast=(beat==len). On rhns: if last go IDLE, else advance addr and beat and go R_REQ. rdata, rid and rlast stay stable while rready=0.
- W_DATA: wready=1. On whns: mem_ce=1, mem_we=~wstrb, mem_wdata=wdata, addr advances, beat++. After beat==len is written, go B_RESP. The beat counter is authoritative; wlast is not used for termination.
- B_RESP: bvalid=1, bid=latched id. On bhns go IDLE.
- Address update: FIXED (2'b00) keeps addr; INCR (2'b01) and WRAP (treated as INCR) add 1 word. Word address wraps modulo 2^MEM_AW. arsize/awsize are ignored; every access is 32-bit.
- rresp/bresp are always OKAY (2'b00); address decode belongs to the interconnect.
- The beat counter is LEN_W bits, compared with the latched len; len=8'hff gives 256 beats with no overflow before termination.

## Timing
- Reset values: arready=0, awready=0, rvalid=0, rlast=0, rdata=0, rid=0, rresp=0, wready=0, bvalid=0, bid=0, bresp=0, mem_ce=0, mem_we=0, mem_addr=0, mem_wdata=0. FSM returns to IDLE.
- Ready/valid outputs are decoded from state. mem_* outputs are combinational from state and latched address; no mem_ce when idle.
- Read: arhns at cycle T, mem_ce at T+1, first rvalid at T+2. Steady throughput is 1 beat per 2 cycles with rready held high.
- Write: awhns at T, wready at T+1. Throughput is 1 beat/cycle and the SRAM is written in the whns cycle. bvalid comes the cycle after the last whns.
- Single outstanding transaction: ar/aw ready=0 in every non-IDLE state.
- Reset asserted mid-burst abandons the transaction immediately. No B or R response is issued, and SRAM writes already done persist.

## Structure
- Shared package axi_slv_pkg: state enum typedef, burst encodings (FIXED/INCR/WRAP), RESP_OKAY, full-word strobe constant.
- A single module; the address/beat generator may be a sub-module axi_burst_addr_gen (latch, step, last flag), shared by both directions.

## Test plan
- Single read: preload word 0x10 = 32'hDEADBEEF; AR addr 0x40, len 0, INCR, id 8'h21 -> rvalid at T+2 with rdata DEADBEEF, rlast=1, rid=21, rresp=0.
- INCR read burst len 3 at addr 0x100 with rready toggled 1/0 -> 4 beats, words 0x40..0x43 in order, rdata stable during stalls, rlast only on beat 4.
- FIXED write len 8'hff to addr 0x200, data = beat index -> one B with bid echoed; word 0x80 ends as 0xFF, word 0x81 untouched.
- Partial strobe: write 32'h11223344 with wstrb 4'b1010 over word holding 0 -> word reads 32'h00220044.
- Simultaneous arvalid and awvalid held for two transactions each -> grants R, W, R, W; no ready asserted outside IDLE.
- rstn pulled low at beat 2 of a 4-beat write -> all valids and readys 0 asynchronously; beats 0-1 persist in SRAM; no bvalid after reset release.
